// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer holding NREGS word-addressed registers.
// Decodes SETUP/ACCESS, answers with a registered one-cycle PREADY pulse and
// flags misaligned or out-of-range accesses on PSLVERR. reg[0] is exported on
// ctrl_out as a sideband control word.
// Optional feature: define APB_SLAVE_WAIT_EN to insert WAIT wait states per
// access; without it the WAIT state and its counter are compiled out and every
// access completes in its first ACCESS cycle.
//
// Handshake: a transfer is one SETUP cycle (psel=1, penable=0) followed by
// ACCESS cycles (psel=1, penable=1) held until pready=1; pready is high for
// exactly one cycle, prdata/pslverr are meaningful only in that cycle, and the
// master may place the next SETUP in that same cycle (back-to-back).
module apb_slave_regs #(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int NREGS = 16,
  parameter int WAIT  = 2
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [ADDR-1:0] paddr,
  input  logic [DATA-1:0] pwdata,
  output logic [DATA-1:0] prdata,
  output logic            pready,
  output logic            pslverr,
  output logic [DATA-1:0] ctrl_out
);

  localparam int              IW   = $clog2(NREGS);
  localparam logic [ADDR-1:0] SPAN = ADDR'(NREGS * 4);

`ifdef APB_SLAVE_WAIT_EN
  localparam int WAIT_EFF = WAIT;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
`else
  localparam int WAIT_EFF = 0;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd2
  } state_t;
`endif

  // Parameter sanity: the index slice assumes a power-of-two register count
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("apb_slave_regs: NREGS must be a power of two >= 2");
  end
  if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
    $error("apb_slave_regs: WAIT must be in 0..15");
  end

  // FSM state; kept as a named signal so checkers can bind to it
  state_t state;

  // Transfer latched at SETUP
  logic            wr_l;
  logic            err_l;
  logic [IW-1:0]   idx_l;
  logic [DATA-1:0] wdata_l;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]      cnt;
`endif

  logic [DATA-1:0] regs [NREGS];

  logic            setup;
  logic            access;
  logic            new_err;
  logic [IW-1:0]   new_idx;
  logic            commit;
  logic [DATA-1:0] fwd_word;
  logic [DATA-1:0] setup_rdata;

  assign setup   = psel & ~penable;
  assign access  = psel & penable;
  assign new_err = (paddr[1:0] != 2'b00) | (paddr >= SPAN);
  assign new_idx = paddr[2 +: IW];

  // A good write commits on the edge that leaves RESP
  assign commit  = (state == ST_RESP) & wr_l & ~err_l;

  assign ctrl_out = regs[0];

  // Read word for a zero-wait response; a write committing on the same edge
  // is forwarded so a back-to-back read of that register sees the new data
  always_comb begin
    fwd_word = regs[new_idx];
    if (commit && (idx_l == new_idx)) begin
      fwd_word = wdata_l;
    end
  end

  assign setup_rdata = (pwrite | new_err) ? '0 : fwd_word;

  // Register file: cleared on reset, updated only by a committing good write
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[idx_l] <= wdata_l;
    end
  end

  // Transfer FSM with registered response outputs (zero outside RESP)
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= ST_IDLE;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      wr_l    <= 1'b0;
      err_l   <= 1'b0;
      idx_l   <= '0;
      wdata_l <= '0;
`ifdef APB_SLAVE_WAIT_EN
      cnt     <= '0;
`endif
    end else begin
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (setup) begin
            wr_l    <= pwrite;
            err_l   <= new_err;
            idx_l   <= new_idx;
            wdata_l <= pwdata;
`ifdef APB_SLAVE_WAIT_EN
            cnt     <= 4'(WAIT_EFF);
            if (WAIT_EFF > 0) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_RESP;
              pready  <= 1'b1;
              pslverr <= new_err;
              prdata  <= setup_rdata;
            end
`else
            state   <= ST_RESP;
            pready  <= 1'b1;
            pslverr <= new_err;
            prdata  <= setup_rdata;
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
`ifdef APB_SLAVE_WAIT_EN
        ST_WAIT: begin
          if (!access) begin
            // Master abandoned the transfer: no response, no write
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state   <= ST_RESP;
              pready  <= 1'b1;
              pslverr <= err_l;
              prdata  <= (wr_l | err_l) ? '0 : regs[idx_l];
            end
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
